// File: rtl/arch_state_rrat.sv
// Retirement register alias table: committed arch->phys map, frees superseded tags, streams map on flush.
// Optional build macro: ARCHSTATE_R0_ZERO_EN hardwires arch reg 0 (never remapped, never freed).
module arch_state_rrat #(
  parameter  int unsigned ARCH_REGS     = 32,
  parameter  int unsigned PR_WIDTH      = 7,
  parameter  int unsigned RETIRE_PORTS  = 4,
  parameter  int unsigned RESTORE_LANES = 8,
  localparam int unsigned ARW           = $clog2(ARCH_REGS),
  localparam int unsigned GRPS          = ARCH_REGS / RESTORE_LANES,
  localparam int unsigned GW            = (GRPS > 1) ? $clog2(GRPS) : 1
) (
  input  logic                              Clk,
  input  logic                              Rest,
  input  logic                              ArchSStop,
  input  logic                              ArchSFlash,
  input  logic [RETIRE_PORTS-1:0]           RetireAble,
  input  logic [RETIRE_PORTS*ARW-1:0]       RetireARAddr,
  input  logic [RETIRE_PORTS*PR_WIDTH-1:0]  RetirePRAddr,
  output logic [RETIRE_PORTS-1:0]           FreeAble,
  output logic [RETIRE_PORTS*PR_WIDTH-1:0]  FreePRAddr,
  output logic                              RestoreValid,
  input  logic                              RestoreReady,
  output logic [GW-1:0]                     RestoreGroup,
  output logic [RESTORE_LANES*PR_WIDTH-1:0] RestoreMap,
  output logic                              RestoreBusy,
  output logic                              RestoreDone,
  output logic [ARCH_REGS*PR_WIDTH-1:0]     MapFlat
);

`ifdef ARCHSTATE_R0_ZERO_EN
  localparam bit R0_ZERO = 1'b1;
`else
  localparam bit R0_ZERO = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_RESTORE, S_DONE} state_t;

  state_t                            state_q;
  logic [GW-1:0]                     group_q;
  logic [PR_WIDTH-1:0]               map_q [ARCH_REGS];
  logic [PR_WIDTH-1:0]               map_d [ARCH_REGS];
  logic [RETIRE_PORTS-1:0]           free_able_q, free_able_d;
  logic [RETIRE_PORTS*PR_WIDTH-1:0]  free_pr_q, free_pr_d;
  logic [ARW-1:0]                    slot_ar;
  logic [PR_WIDTH-1:0]               slot_pr;

  // In-order retire merge: each slot sees the map as left by the older slots.
  always_comb begin
    map_d       = map_q;
    free_able_d = '0;
    free_pr_d   = '0;
    slot_ar     = '0;
    slot_pr     = '0;
    for (int unsigned i = 0; i < RETIRE_PORTS; i++) begin
      slot_ar = RetireARAddr[i*ARW +: ARW];
      slot_pr = RetirePRAddr[i*PR_WIDTH +: PR_WIDTH];
      if (RetireAble[i] && !(R0_ZERO && slot_ar == '0)) begin
        free_able_d[i]                    = 1'b1;
        free_pr_d[i*PR_WIDTH +: PR_WIDTH] = map_d[slot_ar];
        map_d[slot_ar]                    = slot_pr;
      end
    end
  end

  // Table, free outputs and restore walker; stop freezes everything.
  always_ff @(posedge Clk or negedge Rest) begin
    if (!Rest) begin
      state_q     <= S_IDLE;
      group_q     <= '0;
      free_able_q <= '0;
      free_pr_q   <= '0;
      for (int unsigned j = 0; j < ARCH_REGS; j++) begin
        map_q[j] <= PR_WIDTH'(j);
      end
    end else if (!ArchSStop) begin
      if (state_q == S_IDLE) begin
        map_q       <= map_d;
        free_able_q <= free_able_d;
        free_pr_q   <= free_pr_d;
      end else begin
        free_able_q <= '0;
      end
      if (ArchSFlash) begin
        state_q <= S_RESTORE;
        group_q <= '0;
      end else begin
        case (state_q)
          S_RESTORE: begin
            if (RestoreReady) begin
              if (group_q == GW'(GRPS - 1)) begin
                state_q <= S_DONE;
              end else begin
                group_q <= group_q + GW'(1);
              end
            end
          end
          S_DONE:  state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  // Gating by stop keeps a held free or done from being seen twice.
  assign FreeAble     = ArchSStop ? '0 : free_able_q;
  assign FreePRAddr   = free_pr_q;
  assign RestoreValid = (state_q == S_RESTORE);
  assign RestoreBusy  = (state_q != S_IDLE);
  assign RestoreDone  = (state_q == S_DONE) && !ArchSStop;
  assign RestoreGroup = group_q;

  always_comb begin
    RestoreMap = '0;
    for (int unsigned k = 0; k < RESTORE_LANES; k++) begin
      RestoreMap[k*PR_WIDTH +: PR_WIDTH] = map_q[ARW'(32'(group_q) * RESTORE_LANES + k)];
    end
  end

  always_comb begin
    MapFlat = '0;
    for (int unsigned j = 0; j < ARCH_REGS; j++) begin
      MapFlat[j*PR_WIDTH +: PR_WIDTH] = map_q[j];
    end
  end

endmodule

// File: tb/tb_arch_state_rrat.sv
// Directed bench for arch_state_rrat: retire merge, frees, restore walk, flush/stop interplay, r0 option.
module tb_arch_state_rrat;
  localparam int AR = 32, PW = 7, RP = 4, RL = 8, ARW = 5, GW = 2;

  logic              Clk = 1'b0;
  logic              Rest;
  logic              ArchSStop, ArchSFlash, RestoreReady;
  logic [RP-1:0]     RetireAble;
  logic [RP*ARW-1:0] RetireARAddr;
  logic [RP*PW-1:0]  RetirePRAddr;
  logic [RP-1:0]     FreeAble;
  logic [RP*PW-1:0]  FreePRAddr;
  logic              RestoreValid, RestoreBusy, RestoreDone;
  logic [GW-1:0]     RestoreGroup;
  logic [RL*PW-1:0]  RestoreMap;
  logic [AR*PW-1:0]  MapFlat;

  int checks = 0;
  int failures = 0;

  arch_state_rrat dut (
    .Clk(Clk), .Rest(Rest), .ArchSStop(ArchSStop), .ArchSFlash(ArchSFlash),
    .RetireAble(RetireAble), .RetireARAddr(RetireARAddr), .RetirePRAddr(RetirePRAddr),
    .FreeAble(FreeAble), .FreePRAddr(FreePRAddr), .RestoreValid(RestoreValid),
    .RestoreReady(RestoreReady), .RestoreGroup(RestoreGroup), .RestoreMap(RestoreMap),
    .RestoreBusy(RestoreBusy), .RestoreDone(RestoreDone), .MapFlat(MapFlat)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [PW-1:0] ent(input int j);
    return MapFlat[j*PW +: PW];
  endfunction

  function automatic logic [PW-1:0] lane(input int k);
    return RestoreMap[k*PW +: PW];
  endfunction

  function automatic logic [PW-1:0] fpr(input int i);
    return FreePRAddr[i*PW +: PW];
  endfunction

  task automatic set_slot(input int i, input int ar, input int pr);
    RetireAble[i]             = 1'b1;
    RetireARAddr[i*ARW +: ARW] = ARW'(ar);
    RetirePRAddr[i*PW +: PW]   = PW'(pr);
  endtask

  task automatic clr_slots();
    RetireAble   = '0;
    RetireARAddr = '0;
    RetirePRAddr = '0;
  endtask

  initial begin
    Rest = 1'b0; ArchSStop = 1'b0; ArchSFlash = 1'b0; RestoreReady = 1'b0;
    clr_slots();
    tick(); tick();

    // 1: reset state
    for (int j = 0; j < AR; j++) chk($sformatf("reset_map%0d", j), ent(j), j);
    chk("reset_free_able", FreeAble, 0);
    chk("reset_free_pr", FreePRAddr, 0);
    chk("reset_busy", RestoreBusy, 0);
    chk("reset_valid", RestoreValid, 0);
    chk("reset_done", RestoreDone, 0);
    chk("reset_group", RestoreGroup, 0);
    Rest = 1'b1;

    // 2: single retire
    set_slot(0, 5, 40);
    tick();
    chk("t2_free_able", FreeAble, 4'b0001);
    chk("t2_free_pr0", fpr(0), 5);
    chk("t2_map5", ent(5), 40);

    // 3: same-cycle same-arch chain
    clr_slots();
    set_slot(0, 3, 50); set_slot(2, 3, 51); set_slot(3, 7, 52);
    tick();
    chk("t3_free_able", FreeAble, 4'b1101);
    chk("t3_free_pr0", fpr(0), 3);
    chk("t3_free_pr2", fpr(2), 50);
    chk("t3_free_pr3", fpr(3), 7);
    chk("t3_map3", ent(3), 51);
    chk("t3_map7", ent(7), 52);

    // Ready in idle does nothing
    clr_slots();
    RestoreReady = 1'b1;
    tick();
    chk("idle_free_clear", FreeAble, 0);
    chk("idle_ready_busy", RestoreBusy, 0);
    chk("idle_ready_group", RestoreGroup, 0);

    // 4: restore walk, ready 1,0,1,1,1
    RestoreReady = 1'b0; ArchSFlash = 1'b1;
    tick();
    ArchSFlash = 1'b0;
    chk("t4_busy", RestoreBusy, 1);
    chk("t4_valid_g0", RestoreValid, 1);
    chk("t4_group0", RestoreGroup, 0);
    chk("t4_g0_lane3", lane(3), 51);
    chk("t4_g0_lane5", lane(5), 40);
    chk("t4_g0_lane7", lane(7), 52);
    RestoreReady = 1'b1;
    tick();
    chk("t4_group1", RestoreGroup, 1);
    RestoreReady = 1'b0;
    tick();
    chk("t4_hold_group", RestoreGroup, 1);
    chk("t4_hold_valid", RestoreValid, 1);
    chk("t4_hold_lane0", lane(0), 8);
    RestoreReady = 1'b1;
    tick();
    chk("t4_group2", RestoreGroup, 2);
    chk("t4_done_early", RestoreDone, 0);
    tick();
    chk("t4_group3", RestoreGroup, 3);
    chk("t4_g3_lane7", lane(7), 31);
    tick();
    chk("t4_done_pulse", RestoreDone, 1);
    chk("t4_done_valid", RestoreValid, 0);
    chk("t4_done_busy", RestoreBusy, 1);
    RestoreReady = 1'b0;
    tick();
    chk("t4_done_clear", RestoreDone, 0);
    chk("t4_idle_busy", RestoreBusy, 0);

    // 5: flush with same-cycle retire, abort at group 2, stop mid-walk and in DONE
    set_slot(0, 10, 80);
    ArchSFlash = 1'b1;
    tick();
    clr_slots(); ArchSFlash = 1'b0;
    chk("t5_flush_free_able", FreeAble, 4'b0001);
    chk("t5_flush_free_pr0", fpr(0), 10);
    chk("t5_flush_map10", ent(10), 80);
    chk("t5_flush_group", RestoreGroup, 0);
    RestoreReady = 1'b1;
    tick();
    chk("t5_restore_free_clear", FreeAble, 0);
    chk("t5_g1_lane2", lane(2), 80);
    tick();
    chk("t5_group2", RestoreGroup, 2);
    ArchSFlash = 1'b1; RestoreReady = 1'b0;
    tick();
    ArchSFlash = 1'b0;
    chk("t5_reflush_group", RestoreGroup, 0);
    chk("t5_reflush_valid", RestoreValid, 1);
    chk("t5_reflush_done", RestoreDone, 0);
    RestoreReady = 1'b1;
    tick();
    chk("t5_group1", RestoreGroup, 1);
    ArchSStop = 1'b1;
    tick();
    chk("t5_stop_group_a", RestoreGroup, 1);
    chk("t5_stop_valid", RestoreValid, 1);
    tick();
    chk("t5_stop_group_b", RestoreGroup, 1);
    chk("t5_stop_done", RestoreDone, 0);
    ArchSStop = 1'b0;
    tick();
    chk("t5_resume_group2", RestoreGroup, 2);
    tick();
    chk("t5_resume_group3", RestoreGroup, 3);
    tick();
    ArchSStop = 1'b1; RestoreReady = 1'b0;
    #1;
    chk("t5_done_masked", RestoreDone, 0);
    chk("t5_done_busy", RestoreBusy, 1);
    tick();
    chk("t5_done_held_masked", RestoreDone, 0);
    ArchSStop = 1'b0;
    #1;
    chk("t5_done_pulse", RestoreDone, 1);
    tick();
    chk("t5_done_once", RestoreDone, 0);
    chk("t5_idle", RestoreBusy, 0);

    // Stop holds a pending free and ignores retires
    set_slot(0, 9, 70);
    tick();
    chk("stop_free_before", FreeAble, 4'b0001);
    clr_slots(); set_slot(0, 11, 90);
    ArchSStop = 1'b1;
    #1;
    chk("stop_free_masked", FreeAble, 0);
    tick();
    clr_slots(); ArchSStop = 1'b0;
    #1;
    chk("stop_free_after", FreeAble, 4'b0001);
    chk("stop_free_pr0", fpr(0), 9);
    chk("stop_map9", ent(9), 70);
    chk("stop_map11", ent(11), 11);
    tick();
    chk("stop_free_clear", FreeAble, 0);

    // 6: arch reg 0
    set_slot(1, 0, 60);
    tick();
    clr_slots();
`ifdef ARCHSTATE_R0_ZERO_EN
    chk("r0_free_able", FreeAble, 0);
    chk("r0_map0", ent(0), 0);
`else
    chk("r0_free_able", FreeAble, 4'b0010);
    chk("r0_free_pr1", fpr(1), 0);
    chk("r0_map0", ent(0), 60);
`endif
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/arch_state_rrat.md
Name: arch_state_rrat

Overview:
- Parametrised retirement register alias table (RRAT). Holds the committed arch→physical mapping, updated by up to RETIRE_PORTS in-order retirements per cycle.
- Each retirement returns the superseded physical tag to the free list.
- On flush, streams the committed map to the speculative rename table in RESTORE_LANES-wide beats through a valid/ready handshake.
- Sits between the ROB retire stage and the rename stage.

Parameters:
ARCH_REGS, 32, number of architectural registers; power of two.
PR_WIDTH, 7, physical tag width; 2^PR_WIDTH >= ARCH_REGS.
RETIRE_PORTS, 4, retirement slots per cycle, slot 0 oldest.
RESTORE_LANES, 8, map entries per restore beat; divides ARCH_REGS.
Derived: ARW = clog2(ARCH_REGS), GRPS = ARCH_REGS/RESTORE_LANES, GW = max(1, clog2(GRPS)).

Ports:
Clk  in  1  clock, rising edge.
Rest  in  1  asynchronous, active-low reset.
ArchSStop  in  1  freeze all state.
ArchSFlash  in  1  pipeline flush; starts restore walk.
RetireAble  in  RETIRE_PORTS  per-slot retire-with-destination valid.
RetireARAddr  in  RETIRE_PORTS*ARW  slot i arch reg at [i*ARW +: ARW].
RetirePRAddr  in  RETIRE_PORTS*PR_WIDTH  slot i new physical tag.
FreeAble  out  RETIRE_PORTS  slot i freed tag valid.
FreePRAddr  out  RETIRE_PORTS*PR_WIDTH  slot i superseded physical tag.
RestoreValid  out  1  restore beat valid.
RestoreReady  in  1  rename table accepts beat.
RestoreGroup  out  GW  beat index; entries RestoreGroup*RESTORE_LANES onward.
RestoreMap  out  RESTORE_LANES*PR_WIDTH  lane k = table[RestoreGroup*RESTORE_LANES+k].
RestoreBusy  out  1  high while not IDLE.
RestoreDone  out  1  one-cycle pulse after last beat accepted.
MapFlat  out  ARCH_REGS*PR_WIDTH  entire committed table, entry j at [j*PR_WIDTH +: PR_WIDTH].

Behaviour:
- Reset (async, Rest=0): table[j]=j; FSM IDLE; group=0; FreeAble=0; FreePRAddr=0; RestoreValid/Busy/Done=0; MapFlat=identity.
- Priority each cycle: ArchSStop > ArchSFlash > retire/FSM advance.
- Stop: table, FSM, group, free outputs and RestoreDone all hold. FreeAble and RestoreDone are forced 0 during stop so no duplicate frees or pulses occur. Flush in a stopped cycle is ignored; the requestor holds ArchSFlash until stop drops.
- Retire (IDLE, no stop): slots processed in index order.
  - Final table[a] = RetirePRAddr of the highest-index able slot targeting a.
  - Freed tag for slot i = RetirePRAddr of the highest j<i able slot with the same arch reg; if none, table[a] pre-update.
  - FreeAble/FreePRAddr registered, latency 1; FreeAble[i] = RetireAble[i] of the previous cycle.
- Flush with retirements in the same cycle: those retirements are older, so they are applied and freed. FSM then IDLE→RESTORE, group=0. Table is NOT reset to identity.
- RESTORE:
  - RestoreValid=1; RestoreMap reads the current table (already updated).
  - Valid&Ready: group+1. At group GRPS-1, go to DONE.
  - Retire inputs are ignored (RetireAble must be 0; FreeAble stays 0).
- DONE: RestoreDone=1 for one cycle, RestoreValid=0, then IDLE; retirements accepted again from the next cycle.
- Flush in RESTORE or DONE: restart at group 0 in RESTORE; no RestoreDone pulse for the aborted walk.
- Ready without Valid: no effect. Valid holds with stable group/map until accepted.
- GRPS=1: single beat, then DONE.

Optional Feature:
ARCHSTATE_R0_ZERO_EN
- Defined: arch reg 0 is hardwired.
  - Retire slots with RetireARAddr=0 do not update the table and produce FreeAble=0, so the tag is not freed (rename never allocates one for r0).
  - table[0] stays 0 permanently.
- Undefined: r0 is treated like any other register.

Test Plan:
1. Reset, then read MapFlat → entry j = j for all 32; FreeAble=0; RestoreBusy=0.
2. Slot0 AR5→PR40 retire → next cycle FreeAble=0001, FreePRAddr[0]=5; table[5]=40.
3. Same cycle: slot0 AR3→PR50, slot2 AR3→PR51, slot3 AR7→PR52 → table[3]=51, table[7]=52; frees: slot0=3, slot2=50, slot3=7; FreeAble=1101.
4. Flush after test 3, RestoreReady toggled 1,0,1,1,1 → four beats, group 0..3 in order; beat 0 lane 3=51; Valid and map held while Ready=0; RestoreDone pulses once in the cycle after the group-3 accept.
5. Flush at group 2, then re-flush → walk restarts at group 0; a single Done pulse appears at the end. Stop asserted mid-walk → group frozen, no Done pulse until released.
6. With ARCHSTATE_R0_ZERO_EN: retire AR0→PR60 → table[0]=0, FreeAble=0. Without the macro: table[0]=60, free tag 0.
